// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master that frames a 10-bit command word on SS_n/MOSI
// and, for read-data commands (word[9:8]==2'b11), captures an 8-bit reply
// from MISO after RD_LATENCY idle cycles.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - host request, honoured only while busy==0
//   tx_word  - command word: [9:8] opcode, [7:0] payload
//   busy     - frame in progress (falls in the final gap cycle)
//   done     - one-cycle pulse in the cycle SS_n returns high
//   rd_data  - last captured read byte
//   rd_valid - one-cycle pulse with done on read-data frames
//   SS_n     - slave select, active low
//   MOSI     - serial data out, MSB first
//   MISO     - serial data in, MSB first
module spi_master_ctrl #(
  parameter int RD_LATENCY = 3,
  parameter int GAP        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] tx_word,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RECV    = 3'd4,
    ST_END     = 3'd5
  } state_t;

  localparam logic [3:0] SHIFT_LAST = 4'd9;
  localparam logic [3:0] RECV_LAST  = 4'd7;
  localparam logic [3:0] WAIT_LAST  = 4'(RD_LATENCY - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);
  // busy is cleared one cycle before the gap ends so the host's next start
  // is taken at the end of the final gap cycle: SS_n then stays high for
  // exactly GAP cycles between back-to-back frames.
  localparam logic [3:0] BUSY_LAST  = 4'(GAP - 2);

  state_t     state;
  logic [3:0] cnt;
  logic [9:0] word;
  logic [6:0] shreg;

  // Frame sequencer; every output is assigned here, so all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      word     <= 10'd0;
      shreg    <= 7'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_data  <= 8'd0;
      rd_valid <= 1'b0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            word  <= tx_word;
            busy  <= 1'b1;
            SS_n  <= 1'b0;
            MOSI  <= tx_word[9];
            state <= ST_CMD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CMD: begin
          // First SHIFT cycle repeats the command-select bit (cnt=0 -> word[9]).
          cnt   <= 4'd0;
          MOSI  <= word[9];
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cnt == SHIFT_LAST) begin
            cnt  <= 4'd0;
            MOSI <= 1'b0;
            if (word[9:8] == 2'b11) begin
              state <= ST_RD_WAIT;
            end else begin
              SS_n  <= 1'b1;
              done  <= 1'b1;
              busy  <= (GAP_LAST != 4'd0);
              state <= ST_END;
            end
          end else begin
            cnt  <= cnt + 4'd1;
            MOSI <= word[4'd8 - cnt];
          end
        end
        ST_RD_WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt   <= 4'd0;
            state <= ST_RECV;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RECV: begin
          shreg <= {shreg[5:0], MISO};
          if (cnt == RECV_LAST) begin
            rd_data  <= {shreg, MISO};
            rd_valid <= 1'b1;
            done     <= 1'b1;
            SS_n     <= 1'b1;
            busy     <= (GAP_LAST != 4'd0);
            cnt      <= 4'd0;
            state    <= ST_END;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_END: begin
          if (cnt == GAP_LAST) begin
            // busy is already low here, so a pending start is legal this cycle.
            if (start) begin
              word  <= tx_word;
              busy  <= 1'b1;
              SS_n  <= 1'b0;
              MOSI  <= tx_word[9];
              state <= ST_CMD;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt == BUSY_LAST) begin
              busy <= 1'b0;
            end else begin
              busy <= busy;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          SS_n  <= 1'b1;
          MOSI  <= 1'b0;
        end
      endcase
    end
  end

endmodule
